// File: rtl/song_sequencer_pkg.sv
// Shared types and defaults for the beat-timed song sequencer.
package song_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COUNTIN = 3'd1,
        PLAYING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    localparam int SONG_LEN_DEFAULT = 90;
    localparam int COUNTIN_DEFAULT  = 4;

endpackage

// File: rtl/song_sequencer_if.sv
// Control/status bundle between the game datapath and the song sequencer.
interface song_sequencer_if;
    import song_pkg::*;

    logic       start;
    logic       pause;
    logic [7:0] counter;
    logic       beat;
    logic [2:0] countin;
    logic       playing;
    logic       done;
    seq_state_t state;

    modport master (
        output start, pause,
        input  counter, beat, countin, playing, done, state
    );

    modport slave (
        input  start, pause,
        output counter, beat, countin, playing, done, state
    );

endinterface

// File: rtl/song_sequencer_beat_prescaler.sv
// Divides clk down to one beat strobe every TICKS_PER_BEAT cycles while run is high.
module beat_prescaler
    import song_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic beat
);

    localparam int TW = (TICKS_PER_BEAT > 2) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BEAT - 1);

    logic [TW-1:0] tick_q, tick_d;

    // Holding (run low, clear low) preserves beat phase across a pause.
    always_comb begin
        tick_d = tick_q;
        if (clear) begin
            tick_d = '0;
        end else if (run) begin
            tick_d = (tick_q == LAST_TICK) ? '0 : tick_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign beat = run && (tick_q == LAST_TICK);

endmodule

// File: rtl/song_sequencer.sv
// Beat-timed playback controller: count-in, per-beat note index, pause/resume, end-of-song.
// Define SONG_LOOP_EN to wrap the index on the final beat instead of stopping in DONE.
module song_sequencer
    import song_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 25_000_000,
    parameter int SONG_LEN       = SONG_LEN_DEFAULT,
    parameter int COUNTIN_BEATS  = COUNTIN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    song_sequencer_if.slave   bus
);

    localparam logic [7:0] LAST_NOTE   = 8'(SONG_LEN - 1);
    localparam logic [7:0] FULL_INDEX  = 8'(SONG_LEN);
    localparam logic [2:0] COUNTIN_LD  = 3'(COUNTIN_BEATS);

    seq_state_t state_q, state_d;
    logic [7:0] counter_q, counter_d;
    logic [2:0] countin_q, countin_d;
    logic       resume_q, resume_d;
    logic       beat_q, beat_d;
    logic       playing_q, playing_d;
    logic       done_q, done_d;

    logic tick_beat;
    logic pre_run;
    logic pre_clear;

    assign pre_run   = (state_q == COUNTIN) || (state_q == PLAYING);
    assign pre_clear = bus.start || (state_q == IDLE) || (state_q == DONE);

    beat_prescaler #(
        .TICKS_PER_BEAT(TICKS_PER_BEAT)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (pre_run),
        .clear (pre_clear),
        .beat  (tick_beat)
    );

    // The beat is applied first; a coinciding pause then parks whatever state the beat produced.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        countin_d = countin_q;
        resume_d  = resume_q;
        beat_d    = 1'b0;
`ifdef SONG_LOOP_EN
        done_d    = 1'b0;
`else
        done_d    = done_q;
`endif

        if (bus.start) begin
            state_d   = COUNTIN;
            countin_d = COUNTIN_LD;
            counter_d = '0;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    counter_d = '0;
                end
                COUNTIN: begin
                    if (tick_beat) begin
                        beat_d    = 1'b1;
                        countin_d = countin_q - 3'd1;
                        if (countin_q == 3'd1) begin
                            state_d   = PLAYING;
                            counter_d = '0;
                        end
                    end
                end
                PLAYING: begin
                    if (tick_beat) begin
                        beat_d = 1'b1;
                        if (counter_q == LAST_NOTE) begin
`ifdef SONG_LOOP_EN
                            counter_d = '0;
                            done_d    = 1'b1;
`else
                            counter_d = FULL_INDEX;
                            done_d    = 1'b1;
                            state_d   = DONE;
`endif
                        end else begin
                            counter_d = counter_q + 8'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.pause) begin
                        state_d = resume_q ? PLAYING : COUNTIN;
                    end
                end
                default: begin
                end
            endcase

            if (bus.pause && pre_run &&
                ((state_d == COUNTIN) || (state_d == PLAYING))) begin
                resume_d = (state_d == PLAYING);
                state_d  = PAUSED;
            end
        end

        playing_d = (state_d == PLAYING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            countin_q <= '0;
            resume_q  <= 1'b0;
            beat_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            countin_q <= countin_d;
            resume_q  <= resume_d;
            beat_q    <= beat_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.counter = counter_q;
    assign bus.countin = countin_q;
    assign bus.beat    = beat_q;
    assign bus.playing = playing_q;
    assign bus.done    = done_q;

endmodule
